// File: rtl/gpio_cfg_loader_pkg.sv
// Shared types and constants for the GPIO serial configuration loader.
// Field offsets describe one pad's CFG_W-bit word as it lands in the pad control block.
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

package gpio_cfg_loader_pkg;

    localparam int CFG_W_DEFAULT = 13;
    localparam int NPADS_DEFAULT = `MPRJ_IO_PADS;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_CAPT     = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_SHIFT_HI = 3'd4,
        ST_LOAD     = 3'd5,
        ST_DONE     = 3'd6
    } loader_state_t;

    // Per-pad configuration word layout (bit offsets within the CFG_W word)
    localparam int CFG_MGMT_EN_BIT     = 0;
    localparam int CFG_OEB_BIT         = 1;
    localparam int CFG_HOLDOVER_BIT    = 2;
    localparam int CFG_INP_DIS_BIT     = 3;
    localparam int CFG_IB_MODE_SEL_BIT = 4;
    localparam int CFG_ANALOG_EN_BIT   = 5;
    localparam int CFG_ANALOG_SEL_BIT  = 6;
    localparam int CFG_ANALOG_POL_BIT  = 7;
    localparam int CFG_SLOW_SEL_BIT    = 8;
    localparam int CFG_VTRIP_SEL_BIT   = 9;
    localparam int CFG_DM_LSB          = 10;
    localparam int CFG_DM_W            = 3;

endpackage

// File: rtl/gpio_cfg_phase_timer.sv
// Phase timer: o_phase_end marks the last cycle of a serial clock phase (i_div+1 cycles long).
// Divider value is captured on i_load; counter idles at zero whenever i_run is low.
module gpio_cfg_phase_timer #(
    parameter int DIV_W = 4
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_run,
    output logic             o_phase_end
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;

    assign o_phase_end = i_run && (r_cnt == r_div);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_div <= '0;
            r_cnt <= '0;
        end else begin
            if (i_load) begin
                r_div <= i_div;
            end
            // Restart at zero on every phase boundary so each level gets the full count
            if (!i_run || o_phase_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_cfg_loader.sv
// Walks pads NPADS-1..0, reads each word from the register file and shifts it MSB first, then strobes serial_load.
// Optional GPIO_CFG_LOADER_CLKDIV_EN adds a clkdiv input stretching each serial clock level to clkdiv+1 cycles.
module gpio_cfg_loader
    import gpio_cfg_loader_pkg::*;
#(
    parameter int NPADS = `MPRJ_IO_PADS,
    parameter int CFG_W = CFG_W_DEFAULT
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     start,
`ifdef GPIO_CFG_LOADER_CLKDIV_EN
    input  logic [3:0]               clkdiv,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NPADS)-1:0] cfg_rd_addr,
    input  logic [CFG_W-1:0]         cfg_rd_data,
    output logic                     serial_clock,
    output logic                     serial_data_out,
    output logic                     serial_load
);

    localparam int AW = $clog2(NPADS);
    localparam int BW = (CFG_W > 1) ? $clog2(CFG_W) : 1;
    localparam logic [AW-1:0] LAST_PAD = AW'(NPADS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CFG_W - 1);

    loader_state_t    r_state;
    loader_state_t    w_next;
    logic [AW-1:0]    r_pad;
    logic [BW-1:0]    r_bit;
    logic [CFG_W-1:0] r_shreg;
    logic             r_busy;
    logic             r_done;
    logic             r_sclk;
    logic             r_sload;
    logic             w_accept;
    logic             w_in_shift;
    logic             w_phase_end;
    logic [3:0]       w_div;

`ifdef GPIO_CFG_LOADER_CLKDIV_EN
    assign w_div = clkdiv;
`else
    assign w_div = 4'd0;
`endif

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_in_shift = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI);

    gpio_cfg_phase_timer #(
        .DIV_W(4)
    ) u_phase_timer (
        .clock      (clock),
        .resetb     (resetb),
        .i_load     (w_accept),
        .i_div      (w_div),
        .i_run      (w_in_shift),
        .o_phase_end(w_phase_end)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_ADDR;
                end
            end
            ST_ADDR:     w_next = ST_CAPT;
            ST_CAPT:     w_next = ST_SHIFT_LO;
            ST_SHIFT_LO: begin
                if (w_phase_end) begin
                    w_next = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (w_phase_end) begin
                    if (r_bit != '0) begin
                        w_next = ST_SHIFT_LO;
                    end else if (r_pad != '0) begin
                        w_next = ST_ADDR;
                    end else begin
                        w_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD:     w_next = ST_DONE;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change cleanly on the clock edge
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sload <= 1'b0;
        end else begin
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
            r_sclk  <= (w_next == ST_SHIFT_HI);
            r_sload <= (w_next == ST_LOAD);
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_pad   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
        end else begin
            if (w_accept) begin
                r_pad <= LAST_PAD;
            end else if ((r_state == ST_SHIFT_HI) && (w_next == ST_ADDR)) begin
                r_pad <= r_pad - 1'b1;
            end

            if (r_state == ST_CAPT) begin
                r_shreg <= cfg_rd_data;
                r_bit   <= LAST_BIT;
            end else if ((r_state == ST_SHIFT_HI) && (w_next == ST_SHIFT_LO)) begin
                r_shreg <= {r_shreg[CFG_W-2:0], 1'b0};
                r_bit   <= r_bit - 1'b1;
            end
        end
    end

    // The pad index register doubles as the read address, so it holds between reads
    assign cfg_rd_addr     = r_pad;
    assign serial_data_out = r_shreg[CFG_W-1];
    assign serial_clock    = r_sclk;
    assign serial_load     = r_sload;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule
